// File: rtl/trng_bram_if.sv
// Access bus for the TRNG entropy table: enable, write strobe, address, data in/out.
// The master drives the access; the slave (the RAM) returns registered read data.
interface trng_bram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport master (
    output ena,
    output wea,
    output addra,
    output dina,
    input  douta
  );

  modport slave (
    input  ena,
    input  wea,
    input  addra,
    input  dina,
    output douta
  );
endinterface

// File: rtl/trng_bram.sv
// Single-port synchronous RAM holding the TRNG entropy table, preloaded from INIT.
// Define OUTPUT_REG_EN to add a second output register (read latency 2 instead of 1).
module trng_bram #(
  parameter int                              DATA_W     = 8,
  parameter int                              ADDR_W     = 3,
  parameter logic [DATA_W*(2**ADDR_W)-1:0]   INIT       = 64'hD864B20F917EC53A,
  parameter int                              WRITE_MODE = 0
) (
  input logic        clka,
  input logic        rsta_n,
  trng_bram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Word i lives at bits [DATA_W*i +: DATA_W], the same packing as INIT.
  logic [DATA_W*DEPTH-1:0] r_mem = INIT;
  logic [DATA_W-1:0]       r_rdData;
  logic [DATA_W-1:0]       w_rdWord;

  assign w_rdWord = r_mem[DATA_W*bus.addra +: DATA_W];

  always_ff @(posedge clka) begin
    if (bus.ena && bus.wea) begin
      r_mem[DATA_W*bus.addra +: DATA_W] <= bus.dina;
    end
  end

  // WRITE_FIRST forwards the incoming word; READ_FIRST returns the word being replaced.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_rdData <= '0;
    end else if (bus.ena) begin
      if (bus.wea && (WRITE_MODE == 0)) begin
        r_rdData <= bus.dina;
      end else begin
        r_rdData <= w_rdWord;
      end
    end
  end

`ifdef OUTPUT_REG_EN
  logic [DATA_W-1:0] r_outReg;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_outReg <= '0;
    end else if (bus.ena) begin
      r_outReg <= r_rdData;
    end
  end

  assign bus.douta = r_outReg;
`else
  assign bus.douta = r_rdData;
`endif

endmodule

// File: tb/tb_trng_bram.sv
// Self-checking bench for trng_bram: directed spec scenarios, then a randomized access stream.
// The reference model is a byte table plus a queue of enabled-access results, LATENCY deep.
module tb_trng_bram;

  localparam int          DATA_W     = 8;
  localparam int          ADDR_W     = 3;
  localparam logic [63:0] INIT       = 64'hD864B20F917EC53A;
  localparam int          WRITE_MODE = 0;
`ifdef OUTPUT_REG_EN
  localparam int          LATENCY    = 2;
`else
  localparam int          LATENCY    = 1;
`endif

  logic clka;
  logic rsta_n;

  trng_bram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  trng_bram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT      (INIT),
    .WRITE_MODE(WRITE_MODE)
  ) dut (
    .clka  (clka),
    .rsta_n(rsta_n),
    .bus   (bus)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  logic [7:0] refMem [8];
  logic [7:0] resultPipe [$];
  int         compareCount = 0;
  int         failCount    = 0;

  // douta always shows the result of the enabled access LATENCY-1 accesses ago.
  task automatic modelReset();
    resultPipe.delete();
    for (int i = 0; i < LATENCY; i++) resultPipe.push_back(8'h00);
  endtask

  task automatic modelStep(input logic en, input logic we, input logic [2:0] addr,
                           input logic [7:0] din);
    logic [7:0] res;
    if (en) begin
      res = (we && WRITE_MODE == 0) ? din : refMem[addr];
      if (we) refMem[addr] = din;
      resultPipe.push_back(res);
      void'(resultPipe.pop_front());
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] expected;
    expected = resultPipe[0];
    compareCount++;
    assert (bus.douta === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: douta=%h expected=%h", tag, bus.douta, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic we, input logic [2:0] addr,
                               input logic [7:0] din, input string tag);
    @(negedge clka);
    bus.ena   = en;
    bus.wea   = we;
    bus.addra = addr;
    bus.dina  = din;
    @(posedge clka);
    modelStep(en, we, addr, din);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [7:0] tableInit;
    tableInit = 8'h00;
    for (int i = 0; i < 8; i++) refMem[i] = INIT[8*i +: 8];
    modelReset();

    bus.ena   = 1'b0;
    bus.wea   = 1'b0;
    bus.addra = '0;
    bus.dina  = '0;
    rsta_n    = 1'b0;

    #3;
    checkOutput("resetHold");
    #7;
    rsta_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, 3'(i % 8), 8'h00, $sformatf("seqRead%0d", i));
    end
    for (int i = 1; i < LATENCY; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, "seqReadDrain");
    end

    applyStimulus(1'b1, 1'b1, 3'd3, 8'hA5, "writeAddr3");
    for (int i = 1; i < LATENCY; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd3, 8'h00, "writeAddr3Drain");
    end
    applyStimulus(1'b1, 1'b0, 3'd3, 8'h00, "readBackAddr3");
    for (int i = 1; i < LATENCY; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd3, 8'h00, "readBackAddr3Drain");
    end

    applyStimulus(1'b0, 1'b1, 3'd5, 8'hFF, "gatedWriteHold");
    applyStimulus(1'b0, 1'b0, 3'd1, 8'h11, "gatedIdleHold");
    applyStimulus(1'b1, 1'b0, 3'd5, 8'h00, "readAddr5");
    for (int i = 1; i < LATENCY; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd5, 8'h00, "readAddr5Drain");
    end

    applyStimulus(1'b1, 1'b0, 3'd1, 8'h00, "streamA");
    applyStimulus(1'b1, 1'b0, 3'd2, 8'h00, "streamB");
    #2;
    rsta_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midReadReset");
    #1;
    rsta_n = 1'b1;
    for (int i = 0; i < LATENCY; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd6, 8'h00, $sformatf("postResetAddr6_%0d", i));
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(99) < 75, $urandom_range(99) < 30,
                    3'($urandom_range(7)), 8'($urandom), "random");
    end

    for (int i = 0; i < 8 + LATENCY - 1; i++) begin
      applyStimulus(1'b1, 1'b0, 3'(i % 8), 8'h00, $sformatf("finalSweep%0d", i));
    end

    tableInit = refMem[0];
    $display("[TB] model word0 at end = %h", tableInit);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
